// File: rtl/sd_mem_arbiter_if.sv
// Request/busy/ack memory bus shared by both masters and the downstream slave port.
// The master modport issues transfers; the slave modport answers them.
interface sd_mem_arbiter_if;
    logic        request;
    logic        write;
    logic [3:0]  bank;
    logic [23:0] address;
    logic [31:0] wr_data;
    logic        busy;
    logic        ack;
    logic [31:0] rd_data;

    modport master (
        output request, write, bank, address, wr_data,
        input  busy, ack, rd_data
    );

    modport slave (
        input  request, write, bank, address, wr_data,
        output busy, ack, rd_data
    );
endinterface

// File: rtl/sd_mem_arbiter.sv
// Round-robin arbiter merging the host bus (A) and SD DMA (B) onto one memory slave,
// one transfer in flight, with an ack timeout so a dead slave cannot hang the DMA.
module sd_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    sd_mem_arbiter_if.slave       a_bus,
    sd_mem_arbiter_if.slave       b_bus,
    sd_mem_arbiter_if.master      mem_bus,
    output logic                  o_timeout
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        priority_reg, priority_next;   // 1 = B holds priority
    logic        grant_reg, grant_next;         // 1 = B granted
    logic        write_reg, write_next;
    logic [3:0]  bank_reg, bank_next;
    logic [23:0] address_reg, address_next;
    logic [31:0] data_reg, data_next;
    logic [15:0] count_reg, count_next;
    logic        a_ack_reg, a_ack_next;
    logic        b_ack_reg, b_ack_next;
    logic [31:0] a_data_reg, a_data_next;
    logic [31:0] b_data_reg, b_data_next;
    logic        timeout_reg, timeout_next;

    logic        pick_b;
    logic        done;
    logic [31:0] done_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            priority_reg <= 1'b0;
            grant_reg    <= 1'b0;
            write_reg    <= 1'b0;
            bank_reg     <= '0;
            address_reg  <= '0;
            data_reg     <= '0;
            count_reg    <= '0;
            a_ack_reg    <= 1'b0;
            b_ack_reg    <= 1'b0;
            a_data_reg   <= '0;
            b_data_reg   <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            priority_reg <= priority_next;
            grant_reg    <= grant_next;
            write_reg    <= write_next;
            bank_reg     <= bank_next;
            address_reg  <= address_next;
            data_reg     <= data_next;
            count_reg    <= count_next;
            a_ack_reg    <= a_ack_next;
            b_ack_reg    <= b_ack_next;
            a_data_reg   <= a_data_next;
            b_data_reg   <= b_data_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        priority_next = priority_reg;
        grant_next    = grant_reg;
        write_next    = write_reg;
        bank_next     = bank_reg;
        address_next  = address_reg;
        data_next     = data_reg;
        count_next    = count_reg;
        a_ack_next    = 1'b0;
        b_ack_next    = 1'b0;
        a_data_next   = a_data_reg;
        b_data_next   = b_data_reg;
        timeout_next  = 1'b0;
        pick_b        = 1'b0;
        done          = 1'b0;
        done_data     = '0;

        case (state_reg)
            IDLE: begin
                if (a_bus.request || b_bus.request) begin
                    // Contention is resolved by priority; a lone request wins outright.
                    pick_b       = (a_bus.request && b_bus.request) ? priority_reg : b_bus.request;
                    grant_next   = pick_b;
                    write_next   = pick_b ? b_bus.write   : a_bus.write;
                    bank_next    = pick_b ? b_bus.bank    : a_bus.bank;
                    address_next = pick_b ? b_bus.address : a_bus.address;
                    data_next    = pick_b ? b_bus.wr_data : a_bus.wr_data;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_bus.busy) begin
                    count_next = '0;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (count_reg != 16'hFFFF) begin
                    count_next = count_reg + 16'd1;
                end
                // A real ack beats a timeout landing on the same cycle.
                if (mem_bus.ack) begin
                    done      = 1'b1;
                    done_data = mem_bus.rd_data;
                end else if (count_reg == TIMEOUT_LAST) begin
                    done         = 1'b1;
                    done_data    = 32'hFFFF_FFFF;
                    timeout_next = 1'b1;
                end
                if (done) begin
                    if (grant_reg) begin
                        b_ack_next  = 1'b1;
                        b_data_next = done_data;
                    end else begin
                        a_ack_next  = 1'b1;
                        a_data_next = done_data;
                    end
                    priority_next = ~grant_reg;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_bus.request = (state_reg == ISSUE);
    assign mem_bus.write   = write_reg;
    assign mem_bus.bank    = bank_reg;
    assign mem_bus.address = address_reg;
    assign mem_bus.wr_data = data_reg;

    // The granted master sees the slave's accept in the same cycle.
    assign a_bus.busy    = (state_reg == ISSUE && !grant_reg) ? mem_bus.busy : 1'b1;
    assign b_bus.busy    = (state_reg == ISSUE &&  grant_reg) ? mem_bus.busy : 1'b1;
    assign a_bus.ack     = a_ack_reg;
    assign a_bus.rd_data = a_data_reg;
    assign b_bus.ack     = b_ack_reg;
    assign b_bus.rd_data = b_data_reg;
    assign o_timeout     = timeout_reg;
endmodule

// File: tb/tb_sd_mem_arbiter.sv
// Scoreboard bench for sd_mem_arbiter: queued master transactions, a scripted slave,
// and per-scenario tasks comparing logged acks/accepts against expected results.
module tb_sd_mem_arbiter;
    localparam int T = 8;

    typedef struct {
        logic        write;
        logic [3:0]  bank;
        logic [23:0] address;
        logic [31:0] data;
    } tx_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        to;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        to;
        int          cyc;
    } ack_t;

    typedef struct {
        logic        id;
        logic        write;
        logic [3:0]  bank;
        logic [23:0] address;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout;
    always #5 clk = ~clk;

    sd_mem_arbiter_if a_bus ();
    sd_mem_arbiter_if b_bus ();
    sd_mem_arbiter_if mem_bus ();

    sd_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .mem_bus   (mem_bus),
        .o_timeout (timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int to_count = 0;
    int a_req_cyc = 0;
    int b_req_cyc = 0;

    tx_t  a_txq[$];
    tx_t  b_txq[$];
    exp_t exp_q[$];
    ack_t ack_log[$];
    acc_t acc_log[$];

    int          cfg_busy_cycles = 0;
    int          cfg_ack_delay = 0;
    bit          cfg_use_addr = 1'b0;
    logic [31:0] cfg_data = 32'h0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Master A driver: holds request until the accept cycle, then moves to the next queued tx.
    initial begin
        bit acc;
        tx_t t;
        a_bus.request = 1'b0;
        a_bus.write = 1'b0;
        a_bus.bank = '0;
        a_bus.address = '0;
        a_bus.wr_data = '0;
        forever begin
            @(negedge clk);
            acc = a_bus.request && !a_bus.busy;
            @(posedge clk);
            #1;
            if (acc) a_bus.request = 1'b0;
            if (!a_bus.request && a_txq.size() > 0) begin
                t = a_txq.pop_front();
                a_bus.write = t.write;
                a_bus.bank = t.bank;
                a_bus.address = t.address;
                a_bus.wr_data = t.data;
                a_bus.request = 1'b1;
                a_req_cyc = cyc;
            end
        end
    end

    initial begin
        bit acc;
        tx_t t;
        b_bus.request = 1'b0;
        b_bus.write = 1'b0;
        b_bus.bank = '0;
        b_bus.address = '0;
        b_bus.wr_data = '0;
        forever begin
            @(negedge clk);
            acc = b_bus.request && !b_bus.busy;
            @(posedge clk);
            #1;
            if (acc) b_bus.request = 1'b0;
            if (!b_bus.request && b_txq.size() > 0) begin
                t = b_txq.pop_front();
                b_bus.write = t.write;
                b_bus.bank = t.bank;
                b_bus.address = t.address;
                b_bus.wr_data = t.data;
                b_bus.request = 1'b1;
                b_req_cyc = cyc;
            end
        end
    end

    // Scripted slave: busy for cfg_busy_cycles ISSUE cycles, ack cfg_ack_delay cycles after accept.
    initial begin
        bit          acc_flag = 1'b0;
        bit          req_seen = 1'b0;
        int          busy_left = 0;
        int          ack_cd = -1;
        logic [23:0] acc_addr = '0;
        logic [23:0] ack_addr = '0;
        mem_bus.busy = 1'b0;
        mem_bus.ack = 1'b0;
        mem_bus.rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.request && !mem_bus.busy) begin
                acc_flag = 1'b1;
                acc_addr = mem_bus.address;
            end
            @(posedge clk);
            #1;
            if (mem_bus.request && !req_seen) begin
                req_seen = 1'b1;
                busy_left = cfg_busy_cycles;
            end else if (!mem_bus.request) begin
                req_seen = 1'b0;
            end
            mem_bus.busy = req_seen && (busy_left > 0);
            if (busy_left > 0) busy_left--;
            mem_bus.ack = 1'b0;
            if (acc_flag) begin
                acc_flag = 1'b0;
                ack_cd = (cfg_ack_delay > 0) ? cfg_ack_delay - 1 : -1;
                ack_addr = acc_addr;
            end
            if (ack_cd == 0) begin
                mem_bus.ack = 1'b1;
                mem_bus.rd_data = cfg_use_addr ? {8'hC0, ack_addr} : cfg_data;
                ack_cd = -1;
            end else if (ack_cd > 0) begin
                ack_cd--;
            end
        end
    end

    // Passive logger of master acks, slave accepts and timeout pulses.
    initial forever begin
        @(negedge clk);
        if (a_bus.ack) ack_log.push_back('{1'b0, a_bus.rd_data, timeout, cyc});
        if (b_bus.ack) ack_log.push_back('{1'b1, b_bus.rd_data, timeout, cyc});
        if (timeout) to_count++;
        if (mem_bus.request && !mem_bus.busy)
            acc_log.push_back('{(b_bus.busy ? 1'b0 : 1'b1), mem_bus.write, mem_bus.bank,
                                mem_bus.address, mem_bus.wr_data, cyc});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 400000", $time);
        $fatal(1);
    end

    task automatic wait_logs(input int n_ack, input int n_acc, input int max_cycles, input int extra);
        for (int i = 0; i < max_cycles && (ack_log.size() < n_ack || acc_log.size() < n_acc); i++) begin
            @(negedge clk);
            #1;
        end
        repeat (extra) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        ack_log.delete();
        acc_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_bus.request, mem_bus.write, mem_bus.bank, mem_bus.address, mem_bus.wr_data} !== 62'd0) begin
            errors++;
            $display("FAIL reset_slave_outputs: got %h required 0",
                     {mem_bus.request, mem_bus.write, mem_bus.bank, mem_bus.address, mem_bus.wr_data});
        end
        checks++;
        if ({a_bus.busy, b_bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_busy: got %b required 11", {a_bus.busy, b_bus.busy});
        end
        checks++;
        if ({a_bus.ack, b_bus.ack, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ack_timeout: got %b required 000", {a_bus.ack, b_bus.ack, timeout});
        end
        checks++;
        if ({a_bus.rd_data, b_bus.rd_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_master_data: got %h required 0", {a_bus.rd_data, b_bus.rd_data});
        end
        $display("reset checked: outputs idle");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_b_read();
        exp_t e;
        ack_t g;
        ack_log.delete();
        acc_log.delete();
        cfg_busy_cycles = 0;
        cfg_ack_delay = 3;
        cfg_use_addr = 1'b0;
        cfg_data = 32'hDEAD_BEEF;
        b_txq.push_back('{1'b0, 4'd1, 24'h000100, 32'h0});
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
        wait_logs(1, 1, 60, 6);
        checks++;
        if (acc_log.size() != 1) begin
            errors++;
            $display("FAIL b_read_accepts: got %0d accepts required 1", acc_log.size());
        end else begin
            checks++;
            if (acc_log[0].cyc !== b_req_cyc + 1) begin
                errors++;
                $display("FAIL b_read_issue_latency: accept cycle %0d required %0d", acc_log[0].cyc, b_req_cyc + 1);
            end
            checks++;
            if ({acc_log[0].id, acc_log[0].write, acc_log[0].bank, acc_log[0].address} !== {1'b1, 1'b0, 4'd1, 24'h000100}) begin
                errors++;
                $display("FAIL b_read_slave_fields: got %h required %h",
                         {acc_log[0].id, acc_log[0].write, acc_log[0].bank, acc_log[0].address},
                         {1'b1, 1'b0, 4'd1, 24'h000100});
            end
            if (ack_log.size() > 0) begin
                checks++;
                if (ack_log[0].cyc !== acc_log[0].cyc + 4) begin
                    errors++;
                    $display("FAIL b_read_ack_latency: ack cycle %0d required %0d", ack_log[0].cyc, acc_log[0].cyc + 4);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL b_read_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL b_read_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        checks++;
        if (ack_log.size() != 0) begin
            errors++;
            $display("FAIL b_read_extra_ack: got %0d extra acks (first id %0d) required 0", ack_log.size(), ack_log[0].id);
        end
        $display("b_read: B read bank 1 addr 000100 completed");
    endtask

    task automatic test_contention();
        logic exp_ids [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        ack_t g;
        do_reset();
        cfg_busy_cycles = 0;
        cfg_ack_delay = 2;
        cfg_use_addr = 1'b1;
        a_txq.push_back('{1'b0, 4'd2, 24'h0A0000, 32'h0});
        a_txq.push_back('{1'b1, 4'd2, 24'h0A0001, 32'h1111_0001});
        b_txq.push_back('{1'b0, 4'd3, 24'h0B0000, 32'h0});
        b_txq.push_back('{1'b1, 4'd3, 24'h0B0001, 32'h2222_0001});
        exp_q.push_back('{1'b0, 32'hC00A_0000, 1'b0});
        exp_q.push_back('{1'b1, 32'hC00B_0000, 1'b0});
        exp_q.push_back('{1'b0, 32'hC00A_0001, 1'b0});
        exp_q.push_back('{1'b1, 32'hC00B_0001, 1'b0});
        wait_logs(4, 4, 120, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acc_log.size()) begin
                errors++;
                $display("FAIL contention_grant_%0d: no accept, required id %0d", i, exp_ids[i]);
            end else if (acc_log[i].id !== exp_ids[i]) begin
                errors++;
                $display("FAIL contention_grant_%0d: got id %0d required %0d", i, acc_log[i].id, exp_ids[i]);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL contention_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL contention_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        $display("contention: 4 transactions granted A,B,A,B");
    endtask

    task automatic test_busy_hold();
        exp_t e;
        ack_t g;
        logic [65:0] want;
        ack_log.delete();
        acc_log.delete();
        cfg_busy_cycles = 10;
        cfg_ack_delay = 2;
        cfg_use_addr = 1'b1;
        a_txq.push_back('{1'b1, 4'd5, 24'h123456, 32'h1122_3344});
        exp_q.push_back('{1'b0, 32'hC012_3456, 1'b0});
        want = {1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 24'h123456, 32'h1122_3344};
        for (int i = 0; i < 20 && !mem_bus.request; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({mem_bus.request, a_bus.busy, b_bus.busy, mem_bus.write, mem_bus.bank, mem_bus.address, mem_bus.wr_data} !== want) begin
                errors++;
                $display("FAIL busy_hold_cycle_%0d: got %h required %h", i,
                         {mem_bus.request, a_bus.busy, b_bus.busy, mem_bus.write, mem_bus.bank, mem_bus.address, mem_bus.wr_data}, want);
            end
            @(negedge clk);
        end
        checks++;
        if ({mem_bus.request, a_bus.busy, b_bus.busy, mem_bus.address} !== {3'b101, 24'h123456}) begin
            errors++;
            $display("FAIL busy_hold_accept: got %h required %h",
                     {mem_bus.request, a_bus.busy, b_bus.busy, mem_bus.address}, {3'b101, 24'h123456});
        end
        wait_logs(1, 1, 40, 3);
        checks++;
        if (acc_log.size() != 1 || acc_log[0].cyc !== a_req_cyc + 11) begin
            errors++;
            $display("FAIL busy_hold_accept_cycle: got %0d accepts, first cycle %0d required 1 at %0d",
                     acc_log.size(), (acc_log.size() > 0) ? acc_log[0].cyc : -1, a_req_cyc + 11);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL busy_hold_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL busy_hold_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        $display("busy_hold: A write accepted after 10 busy cycles");
    endtask

    task automatic test_timeout();
        logic exp_ids [3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        ack_t g;
        int to_start;
        ack_log.delete();
        acc_log.delete();
        cfg_busy_cycles = 0;
        cfg_ack_delay = 0;
        cfg_use_addr = 1'b0;
        to_start = to_count;
        // Priority is with B here (A completed last), so B goes first.
        b_txq.push_back('{1'b1, 4'd7, 24'hB00001, 32'h5A5A_0001});
        b_txq.push_back('{1'b1, 4'd7, 24'hB00002, 32'h5A5A_0002});
        a_txq.push_back('{1'b0, 4'd6, 24'hA00001, 32'h0});
        exp_q.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
        exp_q.push_back('{1'b0, 32'hFFFF_FFFF, 1'b1});
        exp_q.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
        wait_logs(3, 3, 150, 4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_log.size() || i >= ack_log.size()) begin
                errors++;
                $display("FAIL timeout_txn_%0d: missing accept/ack (%0d/%0d logged)", i, acc_log.size(), ack_log.size());
            end else if ({acc_log[i].id, ack_log[i].cyc} !== {exp_ids[i], acc_log[i].cyc + T + 1}) begin
                errors++;
                $display("FAIL timeout_txn_%0d: got id %0d ack cycle %0d required id %0d ack cycle %0d",
                         i, acc_log[i].id, ack_log[i].cyc, exp_ids[i], acc_log[i].cyc + T + 1);
            end
        end
        checks++;
        if (to_count - to_start != 3) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d required 3", to_count - to_start);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL timeout_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL timeout_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        $display("timeout: B,A,B forced completions with FFFFFFFF");
    endtask

    task automatic test_ack_on_timeout();
        exp_t e;
        ack_t g;
        int to_start;
        ack_log.delete();
        acc_log.delete();
        cfg_busy_cycles = 0;
        cfg_ack_delay = T;
        cfg_use_addr = 1'b1;
        to_start = to_count;
        a_txq.push_back('{1'b0, 4'd9, 24'h0000AA, 32'h0});
        exp_q.push_back('{1'b0, 32'hC000_00AA, 1'b0});
        wait_logs(1, 1, 60, 4);
        checks++;
        if (acc_log.size() != 1 || ack_log.size() != 1 || ack_log[0].cyc !== acc_log[0].cyc + T + 1) begin
            errors++;
            $display("FAIL ack_on_timeout_cycle: got %0d accepts %0d acks, required one ack at accept+%0d",
                     acc_log.size(), ack_log.size(), T + 1);
        end
        checks++;
        if (to_count != to_start) begin
            errors++;
            $display("FAIL ack_on_timeout_pulse: got %0d timeout pulses required 0", to_count - to_start);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL ack_on_timeout_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL ack_on_timeout_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        $display("ack_on_timeout: slave ack on the timeout cycle wins");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        ack_t g;
        ack_log.delete();
        acc_log.delete();
        cfg_busy_cycles = 0;
        cfg_ack_delay = 5;
        cfg_use_addr = 1'b1;
        // A completed last, so priority is B before this reset.
        a_txq.push_back('{1'b0, 4'd4, 24'h000055, 32'h0});
        wait_logs(0, 1, 40, 0);
        checks++;
        if (acc_log.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_accept: got %0d accepts required 1", acc_log.size());
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (ack_log.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_no_ack: got %0d acks (first id %0d) required 0", ack_log.size(), ack_log[0].id);
        end
        checks++;
        if ({mem_bus.request, a_bus.busy, b_bus.busy, timeout} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_mid_idle: got %b required 0110", {mem_bus.request, a_bus.busy, b_bus.busy, timeout});
        end
        checks++;
        if ({a_bus.rd_data, b_bus.rd_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_data: got %h required 0", {a_bus.rd_data, b_bus.rd_data});
        end
        acc_log.delete();
        cfg_ack_delay = 2;
        a_txq.push_back('{1'b0, 4'd4, 24'h000061, 32'h0});
        b_txq.push_back('{1'b0, 4'd4, 24'h000062, 32'h0});
        exp_q.push_back('{1'b0, 32'hC000_0061, 1'b0});
        exp_q.push_back('{1'b1, 32'hC000_0062, 1'b0});
        wait_logs(2, 2, 60, 3);
        checks++;
        if (acc_log.size() < 2 || {acc_log[0].id, acc_log[1].id} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_priority: got %0d accepts, first id %0d required A then B",
                     acc_log.size(), (acc_log.size() > 0) ? acc_log[0].id : 1'bx);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL reset_mid_scoreboard: no ack, required id %0d data %h", e.id, e.data);
            end else begin
                g = ack_log.pop_front();
                if ({g.id, g.data, g.to} !== {e.id, e.data, e.to}) begin
                    errors++;
                    $display("FAIL reset_mid_scoreboard: got id %0d data %h to %b required id %0d data %h to %b",
                             g.id, g.data, g.to, e.id, e.data, e.to);
                end
            end
        end
        $display("reset_mid: abandoned transfer, late ack ignored, priority back to A");
    endtask

    initial begin
        test_reset();
        test_b_read();
        test_contention();
        test_busy_hold();
        test_timeout();
        test_ack_on_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
